// File: rtl/glyph_rom_arbiter.sv
// glyph_rom_arbiter
//   Shares one combinational glyph ROM between two requesters: port 0 (VGA text
//   renderer, priority) and port 1 (keyboard echo/editor). It arbitrates, drives a
//   registered ROM address, captures the glyph and returns it on a valid/ready
//   response channel. A one-entry last-glyph cache short-circuits repeated codes.
//   A starvation counter forces a port-1 win after STARVE_LIMIT consecutive losses.
//   Out-of-range codes read glyph 0 and are flagged with resp_err.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req0_valid/code/ready     port 0 request channel (ready = accepted this cycle)
//   req1_valid/code/ready     port 1 request channel
//   rom_addr, rom_data        registered ROM address, same-cycle ROM data
//   resp_valid/ready          response handshake
//   resp_glyph/id/err         glyph bits, requester id (0/1), out-of-range flag
//   flush                     invalidate the glyph cache
//   busy                      transaction in progress (not idle)
module glyph_rom_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int GLYPH_W      = 512,
  parameter int NUM_GLYPHS   = 26,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [ADDR_W-1:0]  req0_code,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [ADDR_W-1:0]  req1_code,
  output logic               req1_ready,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [GLYPH_W-1:0] rom_data,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [GLYPH_W-1:0] resp_glyph,
  output logic               resp_id,
  output logic               resp_err,
  input  logic               flush,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] CODE_LIMIT = ADDR_W'(NUM_GLYPHS);
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
  logic [GLYPH_W-1:0]   resp_glyph_q, resp_glyph_d;
  logic                 resp_id_q, resp_id_d;
  logic                 resp_err_q, resp_err_d;
  logic [ADDR_W-1:0]    code_q, code_d;
  logic                 flush_seen_q, flush_seen_d;
  logic [CNT_W-1:0]     starve_q, starve_d;
  logic                 cache_valid_q, cache_valid_d;
  logic [ADDR_W-1:0]    cache_tag_q, cache_tag_d;
  logic [GLYPH_W-1:0]   cache_data_q, cache_data_d;

  logic                 in_idle;
  logic                 grant0;
  logic                 grant1;
  logic [ADDR_W-1:0]    sel_code;
  logic                 sel_err;
  logic [ADDR_W-1:0]    sel_clamp;
  logic                 hit;

  // Arbitration is combinational in IDLE; ready doubles as the grant.
  assign in_idle   = (state_q == S_IDLE) && !rst;
  assign grant1    = in_idle && req1_valid && (!req0_valid || (starve_q == STARVE_MAX));
  assign grant0    = in_idle && req0_valid && !grant1;
  assign sel_code  = grant1 ? req1_code : req0_code;
  assign sel_err   = (sel_code >= CODE_LIMIT);
  assign sel_clamp = sel_err ? '0 : sel_code;
  assign hit       = cache_valid_q && !sel_err && !flush && (sel_code == cache_tag_q);

  always_comb begin
    state_d       = state_q;
    rom_addr_d    = rom_addr_q;
    resp_glyph_d  = resp_glyph_q;
    resp_id_d     = resp_id_q;
    resp_err_d    = resp_err_q;
    code_d        = code_q;
    flush_seen_d  = flush_seen_q;
    starve_d      = starve_q;
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;

    case (state_q)
      S_IDLE: begin
        if (!req1_valid || grant1) begin
          starve_d = '0;
        end else if (grant0 && (starve_q != STARVE_MAX)) begin
          starve_d = starve_q + 1'b1;
        end
        if (grant0 || grant1) begin
          code_d       = sel_code;
          resp_id_d    = grant1;
          resp_err_d   = sel_err;
          // A flush in the grant cycle must also block the install in FETCH.
          flush_seen_d = flush;
          if (hit) begin
            resp_glyph_d = cache_data_q;
            state_d      = S_RESP;
          end else begin
            rom_addr_d = sel_clamp;
            state_d    = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        resp_glyph_d = rom_data;
        if (!resp_err_q && !flush && !flush_seen_q) begin
          cache_valid_d = 1'b1;
          cache_tag_d   = code_q;
          cache_data_d  = rom_data;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush) begin
      cache_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rom_addr_q    <= '0;
      resp_glyph_q  <= '0;
      resp_id_q     <= 1'b0;
      resp_err_q    <= 1'b0;
      code_q        <= '0;
      flush_seen_q  <= 1'b0;
      starve_q      <= '0;
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      rom_addr_q    <= rom_addr_d;
      resp_glyph_q  <= resp_glyph_d;
      resp_id_q     <= resp_id_d;
      resp_err_q    <= resp_err_d;
      code_q        <= code_d;
      flush_seen_q  <= flush_seen_d;
      starve_q      <= starve_d;
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rom_addr   = rom_addr_q;
  assign resp_valid = (state_q == S_RESP);
  assign resp_glyph = resp_glyph_q;
  assign resp_id    = resp_id_q;
  assign resp_err   = resp_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule
